// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach (NS / EW) traffic-light scheduler with
// minimum/maximum green, yellow and all-red clearance timing, and latched
// vehicle requests.
// Optional pedestrian walk phase: define PED_WALK_EN to add ped_req, walk and
// the WALK state.
// All timing parameters must lie in 1..63, with GREEN_MIN <= GREEN_MAX.
module intersection_scheduler #(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       req_ns,
  input  logic       req_ew,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
);

  // The state encoding is also the externally visible phase code.
  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_NS_G    = 3'd1,
    ST_NS_Y    = 3'd2,
    ST_EW_G    = 3'd3,
    ST_EW_Y    = 3'd4
`ifdef PED_WALK_EN
    , ST_WALK  = 3'd5
`endif
  } state_e;

  // Final counter value of each phase; the counter is cleared on every state change.
  localparam logic [5:0] GMIN_LAST   = 6'(GREEN_MIN - 1);
  localparam logic [5:0] GMAX_LAST   = 6'(GREEN_MAX - 1);
  localparam logic [5:0] YELLOW_LAST = 6'(YELLOW_T - 1);
  localparam logic [5:0] ALLRED_LAST = 6'(ALLRED_T - 1);
`ifdef PED_WALK_EN
  localparam logic [5:0] WALK_LAST   = 6'(WALK_T - 1);
`endif

  // Direction of the most recently served green.
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       lastDir_q, lastDir_d;
  logic       pendNs_q, pendNs_d;
  logic       pendEw_q, pendEw_d;
`ifdef PED_WALK_EN
  logic       pendPed_q, pendPed_d;
`endif

  logic       pedPending;
  logic       conflictNs;
  logic       conflictEw;
  logic       enterNs;
  logic       enterEw;
  logic       inGreen;
  state_e     vehNext;

`ifdef PED_WALK_EN
  assign pedPending = pendPed_q;
`else
  assign pedPending = 1'b0;
`endif

  // A green is challenged by a pending request from the cross approach or a pedestrian.
  assign conflictNs = pendEw_q | pedPending;
  assign conflictEw = pendNs_q | pedPending;

  assign enterNs = (state_d == ST_NS_G) && (state_q != ST_NS_G);
  assign enterEw = (state_d == ST_EW_G) && (state_q != ST_EW_G);
  assign inGreen = (state_q == ST_NS_G) || (state_q == ST_EW_G);

  // Vehicle arbitration: serve the approach opposite the last green first, then the same one, else default NS.
  always_comb begin
    vehNext = ST_NS_G;
    if (lastDir_q == DIR_EW) begin
      if (pendNs_q) begin
        vehNext = ST_NS_G;
      end else if (pendEw_q) begin
        vehNext = ST_EW_G;
      end
    end else begin
      if (pendEw_q) begin
        vehNext = ST_EW_G;
      end else if (pendNs_q) begin
        vehNext = ST_NS_G;
      end
    end
  end

  // State, counter, direction and request latches; reset drops straight to all-red with nothing pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ALL_RED;
      cnt_q     <= '0;
      lastDir_q <= DIR_EW;
      pendNs_q  <= 1'b0;
      pendEw_q  <= 1'b0;
`ifdef PED_WALK_EN
      pendPed_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lastDir_q <= lastDir_d;
      pendNs_q  <= pendNs_d;
      pendEw_q  <= pendEw_d;
`ifdef PED_WALK_EN
      pendPed_q <= pendPed_d;
`endif
    end
  end

  // Next-state selection; nothing advances while enable is low.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_ALL_RED: begin
          if (cnt_q == ALLRED_LAST) begin
`ifdef PED_WALK_EN
            state_d = pedPending ? ST_WALK : vehNext;
`else
            state_d = vehNext;
`endif
          end
        end
        ST_NS_G: begin
          if (conflictNs && ((!req_ns && (cnt_q >= GMIN_LAST)) || (cnt_q == GMAX_LAST))) begin
            state_d = ST_NS_Y;
          end
        end
        ST_NS_Y: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = ST_ALL_RED;
          end
        end
        ST_EW_G: begin
          if (conflictEw && ((!req_ew && (cnt_q >= GMIN_LAST)) || (cnt_q == GMAX_LAST))) begin
            state_d = ST_EW_Y;
          end
        end
        ST_EW_Y: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = ST_ALL_RED;
          end
        end
`ifdef PED_WALK_EN
        ST_WALK: begin
          if (cnt_q == WALK_LAST) begin
            state_d = vehNext;
          end
        end
`endif
        default: begin
          state_d = ST_ALL_RED;
        end
      endcase
    end
  end

  // Phase counter: clears on a state change, saturates during green, frozen while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (inGreen && (cnt_q == GMAX_LAST)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // Request latches set on any cycle the input is high and clear on entry to the serving phase.
  always_comb begin
    pendNs_d = enterNs ? 1'b0 : (pendNs_q | req_ns);
    pendEw_d = enterEw ? 1'b0 : (pendEw_q | req_ew);
`ifdef PED_WALK_EN
    pendPed_d = ((state_d == ST_WALK) && (state_q != ST_WALK)) ? 1'b0 : (pendPed_q | ped_req);
`endif
  end

  // Remember which approach was served most recently.
  always_comb begin
    lastDir_d = lastDir_q;
    if (enterNs) begin
      lastDir_d = DIR_NS;
    end else if (enterEw) begin
      lastDir_d = DIR_EW;
    end
  end

  // Lamp decode from the state register: red unless in the approach's own green or yellow.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
`ifdef PED_WALK_EN
    walk      = 1'b0;
`endif
    case (state_q)
      ST_NS_G: begin
        ns_red   = 1'b0;
        ns_green = 1'b1;
      end
      ST_NS_Y: begin
        ns_red    = 1'b0;
        ns_yellow = 1'b1;
      end
      ST_EW_G: begin
        ew_red   = 1'b0;
        ew_green = 1'b1;
      end
      ST_EW_Y: begin
        ew_red    = 1'b0;
        ew_yellow = 1'b1;
      end
`ifdef PED_WALK_EN
      ST_WALK: begin
        walk = 1'b1;
      end
`endif
      default: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL provide parameter GREEN_MIN, default 10, minimum green duration in cycles.
REQ-002 SHALL provide parameter GREEN_MAX, default 30, maximum green duration in cycles while a conflict is pending.
REQ-003 SHALL provide parameter YELLOW_T, default 4, yellow duration in cycles.
REQ-004 SHALL provide parameter ALLRED_T, default 2, all-red clearance duration in cycles.
REQ-005 SHALL provide parameter WALK_T, default 8, pedestrian walk duration in cycles.
REQ-006 SHALL provide clk, input, 1 bit, clock; all logic on its rising edge.
REQ-007 SHALL provide reset_n, input, 1 bit, asynchronous, active-low reset.
REQ-008 SHALL provide enable, input, 1 bit; high advances timing, low freezes it.
REQ-009 SHALL provide req_ns and req_ew, inputs, 1 bit each, vehicle-detector requests; pulse or level.
REQ-010 SHALL provide ped_req, input, 1 bit, pedestrian button; present only under PED_WALK_EN.
REQ-011 SHALL provide ns_red, ns_yellow, ns_green, ew_red, ew_yellow and ew_green, outputs, 1 bit each, lamp drives.
REQ-012 SHALL provide walk, output, 1 bit, walk lamp; present only under PED_WALK_EN.
REQ-013 SHALL provide phase, output, 3 bits; ALL_RED=0, NS_G=1, NS_Y=2, EW_G=3, EW_Y=4, WALK=5.

Function
REQ-014 SHALL implement states ALL_RED, NS_G, NS_Y, EW_G, EW_Y and WALK, plus a 6-bit phase counter cleared on every state change; all timing parameters SHALL be in the range 1..63, and GREEN_MIN <= GREEN_MAX.
REQ-015 SHALL decode lamp outputs combinationally from the state register:
- exactly one lamp per approach is high;
- each approach shows red in every state other than its own green or yellow.
REQ-016 SHALL latch requests into pend_ns, pend_ew and pend_ped on any enabled or disabled cycle where the input is high.
- A pending flag clears on the cycle its phase (NS_G, EW_G, WALK) is entered.
- If set and clear coincide on the same cycle, clear wins.
REQ-017 SHALL have each timed phase (NS_Y, EW_Y, ALL_RED, WALK) occupy exactly its parameter count of enabled cycles.
REQ-018 SHALL leave a green state when a conflict is pending (the other approach, or pend_ped) AND either:
- (own request input low and counter >= GREEN_MIN-1), or
- counter == GREEN_MAX-1.
REQ-019 SHALL hold green indefinitely with no pending conflict, with the counter saturating at GREEN_MAX-1.
REQ-020 SHALL route the sequences as follows: NS_G -> NS_Y -> ALL_RED; EW_G -> EW_Y -> ALL_RED.
REQ-021 SHALL choose the next state at the end of ALL_RED, and at the end of WALK, by priority:
- pend_ped -> WALK (not from WALK);
- else the approach opposite last_dir if pending;
- else last_dir's approach if pending;
- else NS_G.
REQ-022 SHALL update register last_dir on green entry.
REQ-023 SHALL hold state, counter and last_dir while enable is low; request latching continues.

Reset
REQ-024 SHALL, on reset_n low, asynchronously force the following:
- state ALL_RED and counter 0;
- pend_* cleared and last_dir=EW;
- outputs ns_red=ew_red=1, all other lamps 0, walk=0, phase=0.
REQ-025 SHALL treat reset mid-phase identically to power-on reset, with no phase completion.
REQ-026 SHALL begin the ALL_RED count on the first enabled clock after reset_n rises.

Configuration
REQ-027 SHALL compile the pedestrian feature only when macro PED_WALK_EN is defined.
REQ-028 SHALL, with PED_WALK_EN defined, provide ped_req, walk, pend_ped and the WALK state; walk=1 only in WALK.
REQ-029 SHALL, without PED_WALK_EN, omit ped_req, walk, pend_ped and WALK; phase never equals 5 and conflicts consider vehicle requests only.

Verification
REQ-030 SHALL cover: reset release, no requests -> phase 0 for 2 cycles, then NS_G rests indefinitely with ns_green=1 and ew_red=1.
REQ-031 SHALL cover: NS_G resting 50 cycles, one-cycle req_ew pulse, req_ns low -> NS_Y on next cycle for 4 cycles, ALL_RED 2, then EW_G.
REQ-032 SHALL cover: EW_G with req_ew held high, req_ns pulsed at EW_G cycle 0 -> EW_G lasts exactly 30 cycles, then EW_Y.
REQ-033 SHALL cover (PED_WALK_EN): ped_req pulsed at NS_G cycle 3, no vehicle requests -> NS_G ends after 10 cycles, NS_Y 4, ALL_RED 2, walk high 8 cycles, then NS_G.
REQ-034 SHALL cover: enable low 5 cycles starting at NS_Y cycle 1 -> all outputs frozen; NS_Y totals 4 enabled cycles.
REQ-035 SHALL cover: reset_n low mid-EW_G with pend_ns set -> immediate all-red, phase 0; after release, NS_G entered via default (pend_ns cleared).
